// File: rtl/cruise_pkg.sv
// ============================================================================
//  Module      : cruise_pkg
//  Description : Shared button indices and default timing for the cruise
//                button conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cruise_pkg;

   localparam int NUM_BTNS = 7;

   localparam int BTN_THROTTLE = 0;
   localparam int BTN_SET      = 1;
   localparam int BTN_ACCEL    = 2;
   localparam int BTN_COAST    = 3;
   localparam int BTN_CANCEL   = 4;
   localparam int BTN_RESUME   = 5;
   localparam int BTN_BRAKE    = 6;

   localparam int DB_CYCLES_DEF    = 4;
   localparam int STUCK_CYCLES_DEF = 200;

   typedef logic [NUM_BTNS-1:0] btn_vec_t;

endpackage

`default_nettype wire

// File: rtl/cruise_debounce.sv
// ============================================================================
//  Module      : cruise_debounce
//  Description : One button channel: two-flop synchronizer, stability
//                counter, debounced level and rising-edge strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cruise_debounce
   import cruise_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic s2,
   output logic db,
   output logic rise
);

   localparam logic [7:0] c_db_target = 8'(DB_CYCLES);

   logic       r_s1;
   logic       r_s2;
   logic       r_db;
   logic       r_db_d;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_db   <= 1'b0;
         r_db_d <= 1'b0;
         r_cnt  <= 8'd0;
      end else begin
         r_s1   <= raw;
         r_s2   <= r_s1;
         r_db_d <= r_db;
         // Any sample agreeing with the current level restarts qualification.
         if (r_s2 == r_db) begin
            r_cnt <= 8'd0;
         end else if (w_cnt_inc == c_db_target) begin
            r_db  <= r_s2;
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign s2   = r_s2;
   assign db   = r_db;
   assign rise = r_db & ~r_db_d;

endmodule

`default_nettype wire

// File: rtl/cruise_btn_cond.sv
// ============================================================================
//  Module      : cruise_btn_cond
//  Description : Conditions raw cruise-control buttons into debounced levels,
//                command pulses and a fast brake path. Optional stuck-button
//                detection is enabled by defining CRUISE_BTN_STUCK_DET_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cruise_btn_cond
   import cruise_pkg::*;
#(
   parameter int DB_CYCLES    = DB_CYCLES_DEF,
   parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic throttle_raw,
   input  logic set_raw,
   input  logic accel_raw,
   input  logic coast_raw,
   input  logic cancel_raw,
   input  logic resume_raw,
   input  logic brake_raw,
   output logic throttle,
   output logic accel,
   output logic coast,
   output logic set,
   output logic cancel,
   output logic resume,
   output logic brake,
   output logic btn_fault
);

   if (DB_CYCLES < 1 || DB_CYCLES > 255 ||
       STUCK_CYCLES < 2 || STUCK_CYCLES > 65535) begin : g_bad_param
      $error("cruise_btn_cond: DB_CYCLES or STUCK_CYCLES out of range");
   end

   btn_vec_t w_raw;
   btn_vec_t w_s2;
   btn_vec_t w_db;
   btn_vec_t w_rise;

   assign w_raw = {brake_raw, resume_raw, cancel_raw, coast_raw,
                   accel_raw, set_raw, throttle_raw};

   for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      cruise_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (w_raw[gi]),
         .s2    (w_s2[gi]),
         .db    (w_db[gi]),
         .rise  (w_rise[gi])
      );
   end

   logic w_fault;
   logic w_stk_cancel;

`ifdef CRUISE_BTN_STUCK_DET_EN
   localparam logic [15:0] c_stuck_last = 16'(STUCK_CYCLES - 1);

   logic [15:0] r_stk_cnt [2];
   logic [1:0]  w_stk_db;
   logic        w_hit;
   logic        r_fault;
   logic        r_stk_cancel;

   assign w_stk_db = {w_db[BTN_RESUME], w_db[BTN_SET]};
   assign w_hit    = (w_stk_db[0] && (r_stk_cnt[0] == c_stuck_last)) ||
                     (w_stk_db[1] && (r_stk_cnt[1] == c_stuck_last));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stk_cnt[0] <= 16'd0;
         r_stk_cnt[1] <= 16'd0;
         r_fault      <= 1'b0;
         r_stk_cancel <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!w_stk_db[i])
               r_stk_cnt[i] <= 16'd0;
            else if (r_stk_cnt[i] != 16'hFFFF)
               r_stk_cnt[i] <= r_stk_cnt[i] + 16'd1;
         end
         // Fault latches; only its first occurrence raises a cancel.
         r_fault      <= r_fault | w_hit;
         r_stk_cancel <= w_hit & ~r_fault;
      end
   end

   assign w_fault      = r_fault;
   assign w_stk_cancel = r_stk_cancel;
`else
   assign w_fault      = 1'b0;
   assign w_stk_cancel = 1'b0;
`endif

   logic w_inhibit;
   logic w_both_dir;
   logic w_set_ok;

   assign brake      = w_s2[BTN_BRAKE] | w_db[BTN_BRAKE];
   assign cancel     = w_rise[BTN_CANCEL] | w_stk_cancel;
   assign w_inhibit  = brake | cancel;
   assign w_both_dir = w_db[BTN_ACCEL] & w_db[BTN_COAST];

   assign throttle   = w_db[BTN_THROTTLE];
   assign accel      = w_db[BTN_ACCEL] & ~w_both_dir & ~w_inhibit;
   assign coast      = w_db[BTN_COAST] & ~w_both_dir & ~w_inhibit;
   assign w_set_ok   = w_rise[BTN_SET] & ~w_inhibit & ~w_fault;
   assign set        = w_set_ok;
   assign resume     = w_rise[BTN_RESUME] & ~w_inhibit & ~w_fault & ~w_set_ok;
   assign btn_fault  = w_fault;

   logic w_unused;
   assign w_unused = &{1'b0, w_s2[BTN_BRAKE-1:0], w_rise[BTN_BRAKE],
                       w_rise[BTN_COAST], w_rise[BTN_ACCEL],
                       w_rise[BTN_THROTTLE]};

endmodule

`default_nettype wire

// File: tb/tb_cruise_btn_cond.sv
// ============================================================================
//  Module      : tb_cruise_btn_cond
//  Description : Self-checking bench for cruise_btn_cond against a
//                window-based behavioural model of the button rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cruise_btn_cond;
   import cruise_pkg::*;

   localparam int DB  = 4;
   localparam int STK = 200;
`ifdef CRUISE_BTN_STUCK_DET_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic throttle_raw = 0, set_raw = 0, accel_raw = 0, coast_raw = 0;
   logic cancel_raw = 0, resume_raw = 0, brake_raw = 0;
   logic throttle, accel, coast, set, cancel, resume, brake, btn_fault;

   int total = 0;
   int bad   = 0;

   bit [15:0] hist     [NUM_BTNS];
   bit        mdb      [NUM_BTNS];
   bit        mrise    [NUM_BTNS];
   int        hold_len [NUM_BTNS];
   bit        mfault;
   bit        mstk_cancel;
   bit [7:0]  exp_o;

   cruise_btn_cond #(.DB_CYCLES(DB), .STUCK_CYCLES(STK)) dut (
      .clk(clk), .reset(reset),
      .throttle_raw(throttle_raw), .set_raw(set_raw), .accel_raw(accel_raw),
      .coast_raw(coast_raw), .cancel_raw(cancel_raw), .resume_raw(resume_raw),
      .brake_raw(brake_raw),
      .throttle(throttle), .accel(accel), .coast(coast), .set(set),
      .cancel(cancel), .resume(resume), .brake(brake), .btn_fault(btn_fault)
   );

   always #5 clk = ~clk;

   function automatic bit [7:0] got_o();
      return {btn_fault, brake, resume, cancel, set, coast, accel, throttle};
   endfunction

   // A level changes once the delayed raw stream has shown DB equal samples
   // that differ from the current level.
   function automatic void model_update(bit [NUM_BTNS-1:0] raw, bit rst);
      bit hit, was, v, stable, brk, can, inh, both, a, c, s, r;
      if (rst) begin
         for (int ch = 0; ch < NUM_BTNS; ch++) begin
            hist[ch] = '0; mdb[ch] = 0; mrise[ch] = 0; hold_len[ch] = 0;
         end
         mfault = 0; mstk_cancel = 0;
      end else begin
         hit = 0;
         for (int ch = 0; ch < NUM_BTNS; ch++) begin
            was = mdb[ch];
            v = hist[ch][1];
            stable = 1;
            for (int k = 1; k <= DB; k++)
               if (hist[ch][k] != v) stable = 0;
            if (stable && v != mdb[ch]) mdb[ch] = v;
            mrise[ch] = mdb[ch] && !was;
            hist[ch] = {hist[ch][14:0], raw[ch]};
            if (!mdb[ch] || mrise[ch]) hold_len[ch] = 0;
            else hold_len[ch]++;
            if ((ch == BTN_SET || ch == BTN_RESUME) && STK_EN && hold_len[ch] == STK)
               hit = 1;
         end
         mstk_cancel = hit && !mfault;
         mfault = mfault || hit;
      end
      brk  = hist[BTN_BRAKE][1] | mdb[BTN_BRAKE];
      can  = mrise[BTN_CANCEL] | mstk_cancel;
      inh  = brk | can;
      both = mdb[BTN_ACCEL] & mdb[BTN_COAST];
      a    = mdb[BTN_ACCEL] & !both & !inh;
      c    = mdb[BTN_COAST] & !both & !inh;
      s    = mrise[BTN_SET] & !inh & !mfault;
      r    = mrise[BTN_RESUME] & !inh & !mfault & !s;
      exp_o = {mfault, brk, r, can, s, c, a, mdb[BTN_THROTTLE]};
   endfunction

   task automatic tick();
      bit [NUM_BTNS-1:0] raw;
      bit rst_now;
      raw = {brake_raw, resume_raw, cancel_raw, coast_raw, accel_raw, set_raw, throttle_raw};
      rst_now = reset;
      @(posedge clk);
      model_update(raw, rst_now);
      #1;
   endtask

   task automatic idle(int n);
      {throttle_raw, set_raw, accel_raw, coast_raw, cancel_raw, resume_raw, brake_raw} = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1;
      {throttle_raw, set_raw, accel_raw, coast_raw, cancel_raw, resume_raw, brake_raw} = '1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (got_o() !== 8'h00) begin
            bad++;
            $display("FAIL reset cyc=%0d got=%b exp=00000000", i, got_o());
         end
      end
      reset = 0;
      idle(10);
   endtask

   task automatic test_set_qualify();
      set_raw = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (set !== (i == 6) || cancel !== 1'b0 || resume !== 1'b0) begin
            bad++;
            $display("FAIL set_qualify cyc=%0d got set/cancel/resume=%b%b%b exp set=%b",
                     i, set, cancel, resume, (i == 6));
         end
      end
      set_raw = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (set !== 1'b0) begin
            bad++;
            $display("FAIL set_release cyc=%0d got set=%b exp=0", i, set);
         end
      end
   endtask

   task automatic test_glitch();
      set_raw = 1;
      for (int i = 1; i <= 15; i++) begin
         if (i == 4) set_raw = 0;
         tick();
         total++;
         if ({set, resume, cancel} !== 3'b000) begin
            bad++;
            $display("FAIL glitch cyc=%0d got set/resume/cancel=%b%b%b exp=000",
                     i, set, resume, cancel);
         end
      end
   endtask

   task automatic test_brake_suppress();
      resume_raw = 1;
      for (int i = 1; i <= 12; i++) begin
         brake_raw = (i == 5);
         tick();
         total++;
         if (brake !== (i == 6) || resume !== 1'b0) begin
            bad++;
            $display("FAIL brake_suppress cyc=%0d got brake=%b resume=%b exp brake=%b resume=0",
                     i, brake, resume, (i == 6));
         end
      end
      idle(10);
   endtask

   task automatic test_accel_coast();
      accel_raw = 1;
      coast_raw = 1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         total++;
         if ({accel, coast} !== 2'b00) begin
            bad++;
            $display("FAIL accel_coast_both cyc=%0d got accel=%b coast=%b exp=00", i, accel, coast);
         end
      end
      coast_raw = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (accel !== (i >= 6) || coast !== 1'b0) begin
            bad++;
            $display("FAIL accel_after_coast cyc=%0d got accel=%b coast=%b exp accel=%b coast=0",
                     i, accel, coast, (i >= 6));
         end
      end
      idle(10);
   endtask

   task automatic test_reset_midcount();
      set_raw = 1;
      for (int i = 1; i <= 4; i++) tick();
      reset = 1;
      tick();
      total++;
      if (got_o() !== 8'h00) begin
         bad++;
         $display("FAIL midcount_reset got=%b exp=00000000", got_o());
      end
      reset = 0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         total++;
         if (set !== (j == 6)) begin
            bad++;
            $display("FAIL midcount_requal cyc=%0d got set=%b exp=%b", j, set, (j == 6));
         end
      end
      idle(10);
   endtask

   task automatic test_stuck();
      int n_cancel = 0;
      int n_set = 0;
      set_raw = 1;
      for (int i = 1; i <= 215; i++) begin
         tick();
         if (cancel) n_cancel++;
         if (set) n_set++;
         total++;
         if (btn_fault !== (STK_EN && i >= 206)) begin
            bad++;
            $display("FAIL stuck_fault cyc=%0d got=%b exp=%b", i, btn_fault, (STK_EN && i >= 206));
         end
      end
      total++;
      if (n_cancel != (STK_EN ? 1 : 0) || n_set != 1) begin
         bad++;
         $display("FAIL stuck_pulses got cancel=%0d set=%0d exp cancel=%0d set=1",
                  n_cancel, n_set, (STK_EN ? 1 : 0));
      end
      set_raw = 0;
      reset = 1;
      tick();
      tick();
      reset = 0;
      idle(5);
   endtask

   task automatic test_random();
      bit [NUM_BTNS-1:0] lv = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int ch = 0; ch < NUM_BTNS; ch++)
            if ($urandom_range(ch == BTN_BRAKE ? 29 : 7) == 0) lv[ch] = ~lv[ch];
         {brake_raw, resume_raw, cancel_raw, coast_raw, accel_raw, set_raw, throttle_raw} = lv;
         reset = reset ? 1'b0 : ($urandom_range(299) == 0);
         tick();
         total++;
         if (got_o() !== exp_o) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b exp=%b (fault,brake,resume,cancel,set,coast,accel,throttle)",
                     cyc, got_o(), exp_o);
         end
      end
      reset = 0;
      idle(10);
   endtask

   initial begin
      test_reset();
      test_set_qualify();
      test_glitch();
      test_brake_suppress();
      test_accel_coast();
      test_reset_midcount();
      test_stuck();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cruise_btn_cond.md
CRUISE_BTN_COND -- requirements
Module: cruise_btn_cond

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive stable cycles required before a debounced level changes (range 1..255).
REQ-002 Parameter STUCK_CYCLES, default 200: hold length, in cycles, at which a set/resume button is declared stuck (range 2..65535).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 throttle_raw, set_raw, accel_raw, coast_raw, cancel_raw, resume_raw, brake_raw  input  1 each  asynchronous driver controls, active-high.
REQ-006 throttle, accel, coast  output  1 each  debounced level commands to the cruise controller.
REQ-007 set, cancel, resume  output  1 each  single-cycle command pulses to the cruise controller.
REQ-008 brake  output  1  fast-path brake level to the cruise controller.
REQ-009 btn_fault  output  1  sticky stuck-button flag; constant 0 when the stuck-detection feature is compiled out.

Function
REQ-010 Each raw input passes through a two-flop synchronizer; s2 denotes the second-stage value.
REQ-011 Per channel, a debounce counter clears when s2 equals the debounced state and increments otherwise; the debounced state takes s2 on the edge where the counter would reach DB_CYCLES.
REQ-012 A raw change held stable from edge N appears on the debounced state at edge N+2+DB_CYCLES; shorter glitches produce no change.
REQ-013 throttle, accel and coast equal their debounced states, except that accel and coast are both forced to 0 while both debounced states are 1.
REQ-014 set, cancel and resume are high for exactly one cycle, in the cycle their debounced state rises; release edges produce no pulse.
REQ-015 brake is the OR of brake s2 and the brake debounced state: it asserts 2 cycles after a raw rise with no debounce and deasserts only via the debounced path.
REQ-016 While brake or the cancel pulse is high, the set and resume pulses are suppressed and accel and coast are forced to 0.
REQ-017 When set and resume pulse in the same cycle, set is emitted and resume is dropped.
REQ-018 Outputs never glitch between edges; all outputs are registered or are direct functions of registered state.

Reset
REQ-019 On reset, every synchronizer flop, debounced state, counter and stuck counter clears to 0.
REQ-020 On reset, all outputs are 0, including btn_fault.
REQ-021 Reset asserted mid-debounce discards the partial count, so no pulse follows reset release unless the input is re-qualified from zero.

Configuration
REQ-022 Macro CRUISE_BTN_STUCK_DET_EN, when defined, adds a 16-bit saturating counter per set/resume channel that counts cycles that debounced state is held high.
REQ-023 With CRUISE_BTN_STUCK_DET_EN defined, reaching STUCK_CYCLES sets btn_fault (sticky until reset) and issues one cancel pulse.
REQ-024 With CRUISE_BTN_STUCK_DET_EN defined, set and resume pulses are blocked while btn_fault is 1.
REQ-025 With CRUISE_BTN_STUCK_DET_EN undefined, btn_fault is tied to 0 and the stuck counters are absent.

Structure
REQ-026 Shared package cruise_pkg holds the button-index constants, NUM_BTNS = 7, and the DB_CYCLES and STUCK_CYCLES defaults.
REQ-027 Sub-module cruise_debounce implements one channel (synchronizer, counter, debounced state, rise strobe) and is instantiated once per input.

Verification (DB_CYCLES = 4, STUCK_CYCLES = 200)
REQ-028 set_raw high for 10 cycles from edge 0 -> set is high only in the cycle after edge 6; no other set activity.
REQ-029 set_raw high for 3 cycles, then low -> set, resume and cancel stay 0 throughout.
REQ-030 brake_raw high for 1 cycle while resume_raw is already debounced and rising -> brake is high for exactly 1 cycle starting 2 cycles later, and the coinciding resume pulse is suppressed.
REQ-031 accel_raw and coast_raw both held high for 20 cycles -> accel = 0 and coast = 0 for the entire window; release coast_raw -> accel = 1 from DB_CYCLES+2 cycles later.
REQ-032 reset pulsed for 1 cycle while the set counter is at 2 -> no set pulse follows; set pulses again only after a fresh 6-cycle qualification.
REQ-033 set_raw held for 210 cycles with CRUISE_BTN_STUCK_DET_EN defined -> btn_fault rises and a single cancel pulse is issued after 200 debounced-high cycles; with the macro undefined -> btn_fault stays 0 and no cancel pulse occurs.
